// File: rtl/uart_ctrl_pkg.sv
// Shared types and constants for the UART command-frame controller.
package uart_ctrl_pkg;

  typedef enum logic [2:0] {
    S_SYNC  = 3'd0,
    S_ADDR  = 3'd1,
    S_DATA  = 3'd2,
    S_CHK   = 3'd3,
    S_WRITE = 3'd4
  } state_t;

  localparam logic [7:0]  DEF_SYNC_BYTE = 8'hA5;
  localparam int unsigned FRAME_LEN     = 4;

endpackage

// File: rtl/uart_cmd_parser.sv
// Decodes [SYNC][ADDR][DATA][CHK] frames from the UART byte strobe into single-cycle
// register writes; malformed or stalled frames are dropped and counted.
module uart_cmd_parser
  import uart_ctrl_pkg::*;
#(
  parameter logic [7:0]  SYNC_BYTE    = DEF_SYNC_BYTE,
  parameter int unsigned ADDR_W       = 4,
  parameter int unsigned TIMEOUT_CLKS = 2000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        rx_byte,
  input  logic              rx_done,
  output logic              reg_wr_en,
  output logic [ADDR_W-1:0] reg_addr,
  output logic [7:0]        reg_wdata,
  output logic              frame_err,
  output logic              busy,
  output logic [7:0]        err_cnt
);

  localparam int unsigned TMR_W = $clog2(TIMEOUT_CLKS);

  state_t           state;
  logic [TMR_W-1:0] timer;
  logic [7:0]       addr_q;
  logic [7:0]       data_q;
  logic             in_frame;
  logic             timeout;
  logic             chk_ok;
  logic             drop;

  assign in_frame = (state == S_ADDR) || (state == S_DATA) || (state == S_CHK);
  // A byte arriving on the expiry cycle takes priority over the timeout.
  assign timeout  = in_frame && !rx_done && (timer == TMR_W'(TIMEOUT_CLKS - 1));
  assign chk_ok   = (rx_byte == (SYNC_BYTE ^ addr_q ^ data_q)) && ((addr_q >> ADDR_W) == '0);
  assign drop     = timeout || ((state == S_CHK) && rx_done && !chk_ok);
  assign busy     = (state != S_SYNC);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_SYNC;
      timer     <= '0;
      addr_q    <= '0;
      data_q    <= '0;
      reg_wr_en <= 1'b0;
      reg_addr  <= '0;
      reg_wdata <= '0;
      frame_err <= 1'b0;
      err_cnt   <= '0;
    end else begin
      reg_wr_en <= 1'b0;
      frame_err <= drop;
      if (drop && (err_cnt != '1))
        err_cnt <= err_cnt + 8'd1;

      if (rx_done || (state == S_SYNC) || timeout)
        timer <= '0;
      else
        timer <= timer + 1'b1;

      unique case (state)
        // The write cycle also hunts for SYNC so a back-to-back frame loses no byte.
        S_SYNC, S_WRITE: begin
          if (rx_done && (rx_byte == SYNC_BYTE))
            state <= S_ADDR;
          else
            state <= S_SYNC;
        end
        S_ADDR: begin
          if (rx_done) begin
            addr_q <= rx_byte;
            state  <= S_DATA;
          end else if (timeout) begin
            state <= S_SYNC;
          end
        end
        S_DATA: begin
          if (rx_done) begin
            data_q <= rx_byte;
            state  <= S_CHK;
          end else if (timeout) begin
            state <= S_SYNC;
          end
        end
        S_CHK: begin
          if (rx_done) begin
            if (chk_ok) begin
              state     <= S_WRITE;
              reg_wr_en <= 1'b1;
              reg_addr  <= addr_q[ADDR_W-1:0];
              reg_wdata <= data_q;
            end else begin
              state <= S_SYNC;
            end
          end else if (timeout) begin
            state <= S_SYNC;
          end
        end
        default: state <= S_SYNC;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_cmd_parser.sv
// Randomized bench for uart_cmd_parser against a frame-level queue model.
module tb_uart_cmd_parser;

  localparam int unsigned TO = 2000;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] rx_byte;
  logic       rx_done;
  logic       reg_wr_en;
  logic [3:0] reg_addr;
  logic [7:0] reg_wdata;
  logic       frame_err;
  logic       busy;
  logic [7:0] err_cnt;

  uart_cmd_parser #(
    .SYNC_BYTE    (8'hA5),
    .ADDR_W       (4),
    .TIMEOUT_CLKS (TO)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .rx_byte   (rx_byte),
    .rx_done   (rx_done),
    .reg_wr_en (reg_wr_en),
    .reg_addr  (reg_addr),
    .reg_wdata (reg_wdata),
    .frame_err (frame_err),
    .busy      (busy),
    .err_cnt   (err_cnt)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Model: bytes of the frame collected so far, idle edges since the last byte.
  logic [7:0]  mq[$];
  int unsigned m_idle = 0;
  logic        m_wr   = 1'b0;
  logic        m_err  = 1'b0;
  logic        m_busy = 1'b0;
  logic [3:0]  m_addr = '0;
  logic [7:0]  m_data = '0;
  logic [7:0]  m_cnt  = '0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_edge(input logic r, input logic d, input logic [7:0] b);
    m_wr  = 1'b0;
    m_err = 1'b0;
    if (r) begin
      mq.delete();
      m_idle = 0;
      m_addr = '0;
      m_data = '0;
      m_cnt  = '0;
    end else if (d) begin
      m_idle = 0;
      if (mq.size() == 0) begin
        if (b == 8'hA5) mq.push_back(b);
      end else begin
        mq.push_back(b);
        if (mq.size() == 4) begin
          if ((mq[3] == (mq[0] ^ mq[1] ^ mq[2])) && (mq[1] < 8'd16)) begin
            m_wr   = 1'b1;
            m_addr = mq[1][3:0];
            m_data = mq[2];
          end else begin
            m_err = 1'b1;
          end
          mq.delete();
        end
      end
    end else if (mq.size() != 0) begin
      m_idle++;
      if (m_idle == TO) begin
        m_err = 1'b1;
        mq.delete();
        m_idle = 0;
      end
    end
    if (m_err && (m_cnt != 8'hFF)) m_cnt = m_cnt + 8'd1;
    m_busy = (mq.size() != 0) || m_wr;
  endtask

  task automatic step(input logic d, input logic [7:0] b);
    rx_done = d;
    rx_byte = b;
    @(posedge clk);
    model_edge(rst, d, b);
    #1;
    check_eq("reg_wr_en", 32'(reg_wr_en), 32'(m_wr));
    check_eq("reg_addr",  32'(reg_addr),  32'(m_addr));
    check_eq("reg_wdata", 32'(reg_wdata), 32'(m_data));
    check_eq("frame_err", 32'(frame_err), 32'(m_err));
    check_eq("busy",      32'(busy),      32'(m_busy));
    check_eq("err_cnt",   32'(err_cnt),   32'(m_cnt));
  endtask

  task automatic send(input logic [7:0] b, input int unsigned gap);
    step(1'b1, b);
    repeat (gap) step(1'b0, 8'($urandom));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step(1'b0, 8'h00);
    rst = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] a, input logic [7:0] dt, input logic [7:0] c,
                            input int unsigned gap);
    send(8'hA5, gap);
    send(a, gap);
    send(dt, gap);
    send(c, gap);
  endtask

  initial begin
    rst     = 1'b1;
    rx_done = 1'b0;
    rx_byte = 8'h00;
    #1;
    do_reset();
    check_eq("reset_busy", 32'(busy), 32'd0);
    check_eq("reset_cnt",  32'(err_cnt), 32'd0);

    // Good frame: write lands in the cycle after the CHK byte.
    send_frame(8'h03, 8'h5C, 8'hFA, 0);
    check_eq("t1_wr",   32'(reg_wr_en), 32'd1);
    check_eq("t1_addr", 32'(reg_addr),  32'h3);
    check_eq("t1_data", 32'(reg_wdata), 32'h5C);
    step(1'b0, 8'h00);
    check_eq("t1_wr_low", 32'(reg_wr_en), 32'd0);

    // Bad checksum, then a good frame.
    send_frame(8'h03, 8'h5C, 8'h00, 0);
    check_eq("t2_err", 32'(frame_err), 32'd1);
    check_eq("t2_cnt", 32'(err_cnt), 32'd1);
    send_frame(8'h07, 8'h11, 8'hB3, 1);
    check_eq("t2_data", 32'(reg_wdata), 32'h11);

    // Gap of 1999 idle edges is still accepted; 2000 idle edges times out.
    send(8'hA5, TO - 1);
    send(8'h03, TO - 1);
    check_eq("t3_busy_hold", 32'(busy), 32'd1);
    check_eq("t3_no_err",    32'(frame_err), 32'd0);
    step(1'b0, 8'h00);
    check_eq("t3_err",  32'(frame_err), 32'd1);
    check_eq("t3_busy", 32'(busy), 32'd0);
    send(8'h5C, 2);
    send(8'hFA, 2);

    // Correct checksum but address out of range.
    send_frame(8'h13, 8'h5C, 8'hEA, 0);
    check_eq("t4_err", 32'(frame_err), 32'd1);
    check_eq("t4_cnt", 32'(err_cnt), 32'd3);

    // Garbage, then back-to-back frames with SYNC in the write cycle.
    send(8'h00, 0);
    send(8'hFF, 0);
    send(8'h12, 0);
    send_frame(8'h03, 8'h5C, 8'hFA, 0);
    send_frame(8'h04, 8'h20, 8'h81, 0);
    check_eq("t5_wr",   32'(reg_wr_en), 32'd1);
    check_eq("t5_addr", 32'(reg_addr),  32'h4);
    check_eq("t5_cnt",  32'(err_cnt),   32'd3);

    // Reset mid-frame, then saturate the error counter.
    do_reset();
    send(8'hA5, 0);
    send(8'h03, 0);
    do_reset();
    check_eq("t6_busy", 32'(busy), 32'd0);
    check_eq("t6_err",  32'(frame_err), 32'd0);
    check_eq("t6_cnt",  32'(err_cnt), 32'd0);
    for (int i = 0; i < 300; i++) send_frame(8'h00, 8'h00, 8'h00, 0);
    check_eq("t6_sat", 32'(err_cnt), 32'hFF);
    do_reset();

    // Randomized mix of good, corrupt, garbage and stalled traffic.
    for (int n = 0; n < 400; n++) begin
      automatic int unsigned kind = $urandom_range(0, 19);
      automatic logic [7:0]  a    = 8'($urandom_range(0, 15));
      automatic logic [7:0]  dt   = 8'($urandom);
      automatic logic [7:0]  c    = 8'hA5 ^ a ^ dt;
      automatic int unsigned g    = $urandom_range(0, 3);
      case (kind)
        0, 1:    send(8'($urandom), g);
        2:       begin a[7:4] = 4'($urandom_range(1, 15)); c = 8'hA5 ^ a ^ dt;
                   send_frame(a, dt, c, g); end
        3:       send_frame(a, dt, c ^ 8'($urandom_range(1, 255)), g);
        4:       begin send(8'hA5, g); send(a, TO - 2 + $urandom_range(0, 3)); send(dt, g); end
        5:       if ($urandom_range(0, 9) == 0) do_reset(); else send_frame(a, dt, c, g);
        default: send_frame(a, dt, c, g);
      endcase
    end
    repeat (TO + 2) step(1'b0, 8'h00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
